bitreverse_var: RTL and testbench

- Runtime-sizable successor to the fixed-size pipelined FFT bit-reverse reorder stage.
- Sits at the FFT output. Reorders frames of 2^L complex samples, with L selectable per frame up to MAX_LGSIZE.
- Also offers a natural-order bypass mode with identical latency.
- Uses ping-pong buffering: one bank is written while the other is read.

---
 rtl/bitreverse_pkg.sv | 33 +++
 rtl/bitrev_addr.sv | 20 ++
 rtl/bitreverse_var.sv | 145 ++++++++++++++
 tb/tb_bitreverse_var.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitreverse_pkg.sv
// Shared types and helpers for the variable-size bit-reverse reorder stage.
// Holds the frame-alignment state type, size defaults, size clamp and bit reversal.
package bitreverse_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int DEF_MAX_LGSIZE = 5;
    localparam int DEF_MIN_LGSIZE = 2;

    // Fixed container width for the helpers so they serve any MAX_LGSIZE up to 16.
    localparam int FN_W = 16;

    function automatic int clamp_lg(input int lg, input int min_lg, input int max_lg);
        if (lg < min_lg) return min_lg;
        if (lg > max_lg) return max_lg;
        return lg;
    endfunction

    function automatic logic [FN_W-1:0] rev_bits(input logic [FN_W-1:0] off,
                                                 input int              lg,
                                                 input int              max_lg);
        logic [FN_W-1:0] r;
        r = '0;
        for (int i = 0; i < FN_W; i++) begin
            if (i < max_lg) r[max_lg-1-i] = off[i];
        end
        return r >> (max_lg - lg);
    endfunction

endpackage

// File: rtl/bitrev_addr.sv
// Read-address generator: natural order when bypassed, otherwise the low rd_lg
// bits of the write offset reversed.
module bitrev_addr
    import bitreverse_pkg::*;
#(
    parameter int MAX_LGSIZE = DEF_MAX_LGSIZE,
    parameter int LGW        = $clog2(MAX_LGSIZE + 1)
) (
    input  logic [MAX_LGSIZE-1:0] off_i,
    input  logic [LGW-1:0]        rd_lg_i,
    input  logic                  rd_byp_i,
    output logic [MAX_LGSIZE-1:0] raddr_o
);

    always_comb begin
        raddr_o = rd_byp_i ? off_i
                           : MAX_LGSIZE'(rev_bits(FN_W'(off_i), int'(rd_lg_i), MAX_LGSIZE));
    end

endmodule

// File: rtl/bitreverse_var.sv
// Ping-pong bit-reverse reorder stage with per-frame size and bypass selection.
// Optional BITREVERSE_VAR_SYNCIN_EN adds i_sync to realign frames to an external start.
module bitreverse_var
    import bitreverse_pkg::*;
#(
    parameter int MAX_LGSIZE = DEF_MAX_LGSIZE,
    parameter int MIN_LGSIZE = DEF_MIN_LGSIZE,
    parameter int WIDTH      = 24,
    parameter int LGW        = $clog2(MAX_LGSIZE + 1)
) (
    input  logic               i_clk,
    input  logic               i_areset_n,
    input  logic               i_ce,
    input  logic [LGW-1:0]     i_lgsize,
    input  logic               i_bypass,
    input  logic [2*WIDTH-1:0] i_in,
`ifdef BITREVERSE_VAR_SYNCIN_EN
    input  logic               i_sync,
`endif
    output logic [2*WIDTH-1:0] o_out,
    output logic               o_sync,
    output logic [LGW-1:0]     o_lgsize
);

    localparam int DEPTH = 2 ** (MAX_LGSIZE + 1);

    logic [2*WIDTH-1:0]    mem [DEPTH];

    state_e                state_q, state_d;
    logic [MAX_LGSIZE-1:0] off_q, off_d;
    logic                  bank_q, bank_d;
    logic [LGW-1:0]        wr_lg_q, wr_lg_d;
    logic                  wr_byp_q, wr_byp_d;
    logic [LGW-1:0]        rd_lg_q, rd_lg_d;
    logic                  rd_byp_q, rd_byp_d;
    logic [2*WIDTH-1:0]    out_q, out_d;
    logic                  sync_q, sync_d;
    logic [LGW-1:0]        lgsize_q, lgsize_d;

    logic [LGW-1:0]        lg_clamped;
    logic [MAX_LGSIZE-1:0] last_off;
    logic [MAX_LGSIZE-1:0] raddr;
    logic [MAX_LGSIZE:0]   waddr;
    logic                  boundary;
    logic                  realign;

    assign lg_clamped = LGW'(clamp_lg(int'(i_lgsize), MIN_LGSIZE, MAX_LGSIZE));
    assign last_off   = MAX_LGSIZE'((32'd1 << wr_lg_q) - 32'd1);
    assign boundary   = (off_q == last_off);

`ifdef BITREVERSE_VAR_SYNCIN_EN
    assign realign = i_sync && (off_q != '0);
`else
    assign realign = 1'b0;
`endif

    // A realigning sample becomes word 0 of the other bank.
    assign waddr = realign ? {~bank_q, MAX_LGSIZE'(0)} : {bank_q, off_q};

    bitrev_addr #(
        .MAX_LGSIZE (MAX_LGSIZE),
        .LGW        (LGW)
    ) u_addr (
        .off_i    (off_q),
        .rd_lg_i  (rd_lg_q),
        .rd_byp_i (rd_byp_q),
        .raddr_o  (raddr)
    );

    always_comb begin
        // NOTE: every next-state signal defaults to its register first, so no path infers a latch.
        state_d  = state_q;
        off_d    = off_q;
        bank_d   = bank_q;
        wr_lg_d  = wr_lg_q;
        wr_byp_d = wr_byp_q;
        rd_lg_d  = rd_lg_q;
        rd_byp_d = rd_byp_q;
        out_d    = out_q;
        sync_d   = sync_q;
        lgsize_d = lgsize_q;

        if (i_ce) begin
            out_d  = mem[{~bank_q, raddr}];
            sync_d = (state_q == RUN) && (off_q == '0);
            if (sync_d) lgsize_d = rd_lg_q;

            if (boundary) begin
                off_d    = '0;
                bank_d   = ~bank_q;
                rd_lg_d  = wr_lg_q;
                rd_byp_d = wr_byp_q;
                wr_lg_d  = lg_clamped;
                wr_byp_d = i_bypass;
                // A size change misaligns the next read pass, so that frame is output unsynced.
                state_d  = (lg_clamped != wr_lg_q) ? PRIME : RUN;
            end else begin
                off_d = off_q + MAX_LGSIZE'(1);
            end

            if (realign) begin
                off_d   = MAX_LGSIZE'(1);
                bank_d  = ~bank_q;
                state_d = PRIME;
            end
        end
    end

    // NOTE: sample storage has no reset; words are always written before a synced frame reads them.
    always_ff @(posedge i_clk) begin
        if (i_ce) mem[waddr] <= i_in;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q  <= PRIME;
            off_q    <= '0;
            bank_q   <= 1'b0;
            wr_lg_q  <= lg_clamped;
            wr_byp_q <= 1'b0;
            rd_lg_q  <= lg_clamped;
            rd_byp_q <= 1'b0;
            out_q    <= '0;
            sync_q   <= 1'b0;
            lgsize_q <= lg_clamped;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            bank_q   <= bank_d;
            wr_lg_q  <= wr_lg_d;
            wr_byp_q <= wr_byp_d;
            rd_lg_q  <= rd_lg_d;
            rd_byp_q <= rd_byp_d;
            out_q    <= out_d;
            sync_q   <= sync_d;
            lgsize_q <= lgsize_d;
        end
    end

    assign o_out    = out_q;
    assign o_sync   = sync_q;
    assign o_lgsize = lgsize_q;

endmodule

// File: tb/tb_bitreverse_var.sv
// Self-checking bench for bitreverse_var: a frame-level reference model checked every
// cycle, plus hand-computed literal sequences for the directed scenarios.
module tb_bitreverse_var;

    localparam int W = 24;

    logic            i_clk;
    logic            i_areset_n;
    logic            i_ce;
    logic [2:0]      i_lgsize;
    logic            i_bypass;
    logic [2*W-1:0]  i_in;
`ifdef BITREVERSE_VAR_SYNCIN_EN
    logic            i_sync;
`endif
    logic [2*W-1:0]  o_out;
    logic            o_sync;
    logic [2:0]      o_lgsize;

    bitreverse_var dut (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_ce       (i_ce),
        .i_lgsize   (i_lgsize),
        .i_bypass   (i_bypass),
        .i_in       (i_in),
`ifdef BITREVERSE_VAR_SYNCIN_EN
        .i_sync     (i_sync),
`endif
        .o_out      (o_out),
        .o_sync     (o_sync),
        .o_lgsize   (o_lgsize)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model: frames are collected whole, and the frame written
    // during frame n+1 is emitted in reversed (or natural) order when both sizes match.
    logic [2*W-1:0] m_cur[$];
    logic [2*W-1:0] m_prev[$];
    int             m_cur_lg, m_prev_lg, m_fno;
    logic           m_cur_byp, m_prev_byp, m_prev_ok;
    logic [2*W-1:0] nx_out, exp_out;
    logic           nx_sync, exp_sync, nx_valid, exp_valid;
    logic [2:0]     nx_lg, exp_lg;
    bit             chk_en = 1'b0;

    int rev8[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int rev16[4] = '{0, 8, 4, 12};
    int rev32[4] = '{0, 16, 8, 24};

    function automatic int clamp_m(input int lg);
        return (lg < 2) ? 2 : ((lg > 5) ? 5 : lg);
    endfunction

    function automatic int rev_m(input int k, input int lg);
        int r = 0;
        int v = k;
        for (int b = 0; b < lg; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic commit();
        exp_out   = nx_out;
        exp_sync  = nx_sync;
        exp_valid = nx_valid;
        exp_lg    = nx_lg;
    endtask

    task automatic model_reset();
        m_cur.delete();
        m_prev.delete();
        m_prev_ok = 1'b0;
        m_cur_lg  = clamp_m(int'(i_lgsize));
        m_cur_byp = 1'b0;
        m_prev_lg = 0;
        m_prev_byp = 1'b0;
        m_fno     = 0;
        nx_out    = '0;
        nx_sync   = 1'b0;
        nx_valid  = 1'b1;
        nx_lg     = 3'(m_cur_lg);
        commit();
    endtask

    task automatic model_step(input logic [2*W-1:0] d, input logic s);
        int j;
        if (s && m_cur.size() != 0) begin
            m_cur.delete();
            m_prev_ok = 1'b0;
        end
        j = m_cur.size();
        if (m_prev_ok && m_cur_lg == m_prev_lg) begin
            nx_valid = 1'b1;
            nx_out   = m_prev[m_prev_byp ? j : rev_m(j, m_prev_lg)];
            nx_sync  = (j == 0);
            if (j == 0) nx_lg = 3'(m_prev_lg);
        end else begin
            nx_valid = 1'b0;
            nx_sync  = 1'b0;
        end
        m_cur.push_back(d);
        if (m_cur.size() == (1 << m_cur_lg)) begin
            m_prev     = m_cur;
            m_prev_lg  = m_cur_lg;
            m_prev_byp = m_cur_byp;
            m_prev_ok  = 1'b1;
            m_cur.delete();
            m_cur_lg   = clamp_m(int'(i_lgsize));
            m_cur_byp  = i_bypass;
            m_fno++;
        end
    endtask

    task automatic tick(input logic ce, input logic [2*W-1:0] d, input logic s);
        i_ce = ce;
        i_in = d;
`ifdef BITREVERSE_VAR_SYNCIN_EN
        i_sync = s;
`endif
        if (ce) model_step(d, s);
        @(posedge i_clk);
        #1;
        commit();
    endtask

    // One strobe carrying {frame number, position in frame}, then `gap` idle clocks.
    task automatic strobe(input int gap);
        tick(1'b1, {W'(m_fno), W'(m_cur.size())}, 1'b0);
        for (int g = 0; g < gap; g++) tick(1'b0, 48'hBADBADBADBAD, 1'b0);
    endtask

    task automatic do_reset(input logic [2:0] lg, input int lg_lit);
        i_lgsize   = lg;
        i_bypass   = 1'b0;
        i_ce       = 1'b0;
        i_areset_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        check("rst_out", o_out, 0);
        check("rst_sync", o_sync, 0);
        check("rst_lgsize", o_lgsize, lg_lit);
        repeat (2) @(posedge i_clk);
        #1;
        i_areset_n = 1'b1;
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("sync", o_sync, exp_sync);
            check("lgsize", o_lgsize, exp_lg);
            if (exp_valid) check("out", o_out, exp_out);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic reversed_run(input int gap, input string tag);
        int n_sync = 0;
        do_reset(3'd3, 3);
        for (int k = 0; k < 8; k++) begin
            strobe(gap);
            if (o_sync) n_sync++;
        end
        check({tag, "_presync"}, n_sync, 0);
        for (int k = 0; k < 8; k++) begin
            strobe(gap);
            check({tag, "_rev"}, o_out[W-1:0], rev8[k]);
            if (k == 0) begin
                check({tag, "_sync"}, o_sync, 1);
                check({tag, "_lg"}, o_lgsize, 3);
            end
        end
        for (int k = 0; k < 8; k++) strobe(gap);
    endtask

    initial begin
        int n_sync;
        int first;
        i_areset_n = 1'b1;
        i_ce       = 1'b0;
        i_lgsize   = 3'd3;
        i_bypass   = 1'b0;
        i_in       = '0;
`ifdef BITREVERSE_VAR_SYNCIN_EN
        i_sync     = 1'b0;
`endif
        @(posedge i_clk);
        #1;

        reversed_run(0, "cont");
        reversed_run(2, "gap3");

        // Size change 3 -> 4 mid-frame.
        do_reset(3'd3, 3);
        for (int k = 0; k < 13; k++) strobe(0);
        i_lgsize = 3'd4;
        for (int k = 0; k < 3; k++) strobe(0);
        n_sync = 0;
        for (int k = 0; k < 16; k++) begin
            strobe(0);
            if (o_sync) n_sync++;
        end
        check("resize_prime_nosync", n_sync, 0);
        for (int k = 0; k < 16; k++) begin
            strobe(0);
            if (k < 4) check("resize_rev16", o_out[W-1:0], rev16[k]);
            if (k == 0) begin
                check("resize_sync", o_sync, 1);
                check("resize_lg", o_lgsize, 4);
            end
        end

        // Bypass on for one frame, then back off.
        do_reset(3'd3, 3);
        i_bypass = 1'b1;
        for (int k = 0; k < 8; k++) strobe(0);
        strobe(0);
        i_bypass = 1'b0;
        for (int k = 0; k < 7; k++) strobe(0);
        for (int k = 0; k < 8; k++) begin
            strobe(0);
            check("byp_natural", o_out[W-1:0], k);
            if (k == 0) check("byp_sync", o_sync, 1);
        end
        strobe(0);
        check("byp_off_sync", o_sync, 1);
        check("byp_off_first", o_out[W-1:0], 0);
        strobe(0);
        check("byp_off_second", o_out[W-1:0], 4);
        for (int k = 0; k < 6; k++) strobe(0);

        // Reset at sample 3 of frame 2.
        do_reset(3'd3, 3);
        for (int k = 0; k < 19; k++) strobe(0);
        do_reset(3'd3, 3);
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            strobe(0);
            if (o_sync) first = k;
        end
        check("reset_first_sync", first, 9);

        // Size clamping: below minimum, then above maximum.
        do_reset(3'd1, 2);
        for (int k = 0; k < 6; k++) strobe(0);
        i_lgsize = 3'd7;
        for (int k = 0; k < 2; k++) strobe(0);
        n_sync = 0;
        for (int k = 0; k < 32; k++) begin
            strobe(0);
            if (o_sync) n_sync++;
        end
        check("clamp_prime_nosync", n_sync, 0);
        for (int k = 0; k < 32; k++) begin
            strobe(0);
            if (k < 4) check("clamp_rev32", o_out[W-1:0], rev32[k]);
            if (k == 0) begin
                check("clamp_sync", o_sync, 1);
                check("clamp_lg", o_lgsize, 5);
            end
        end

`ifdef BITREVERSE_VAR_SYNCIN_EN
        // Realign on i_sync at offset 3.
        do_reset(3'd3, 3);
        for (int k = 0; k < 19; k++) strobe(0);
        n_sync = 0;
        tick(1'b1, {W'(m_fno), W'(0)}, 1'b1);
        if (o_sync) n_sync++;
        for (int k = 0; k < 7; k++) begin
            strobe(0);
            if (o_sync) n_sync++;
        end
        check("syncin_nosync", n_sync, 0);
        for (int k = 0; k < 8; k++) begin
            strobe(0);
            check("syncin_rev", o_out[W-1:0], rev8[k]);
            if (k == 0) check("syncin_sync", o_sync, 1);
        end
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
